// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared port-sequencer state encoding and sizing constants for the LC-3 memory responder.
package lc3_mem_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } port_state_e;
  localparam int ADDR_W_DEF = 8;
  localparam int LAT_MAX = 15;
  localparam int CNT_W = $clog2(LAT_MAX + 1);
endpackage

// File: rtl/lc3_mem_port_fsm.sv
// lc3_mem_port_fsm: IDLE/WAIT/DONE access sequencer; fire_o marks the edge entering DONE, complete_o is the DONE cycle.
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic req_i,
  output logic accept_o,
  output logic fire_o,
  output logic complete_o
);
  port_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_o   = 1'b0;
    fire_o     = 1'b0;
    complete_o = 1'b0;
    case (state_q)
      ST_IDLE: if (req_i) begin
        accept_o = 1'b1;
        state_d  = ST_WAIT;
        cnt_d    = CNT_W'(LAT);
      end
      ST_WAIT: if (cnt_q == '0) begin
        fire_o  = 1'b1;
        state_d = ST_DONE;
      end else cnt_d = cnt_q - 1'b1;
      ST_DONE: begin
        complete_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: dual-port (instruction read / data read-write) memory with independent fixed-latency handshakes.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int I_LAT  = 1,
  parameter int D_LAT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              I_macc,
  input  logic              instrmem_rd,
  input  logic [15:0]       pc,
  input  logic              D_macc,
  input  logic              Data_rd,
  input  logic [15:0]       Data_addr,
  input  logic [15:0]       Data_din,
  output logic [15:0]       Instr_dout,
  output logic              complete_instr,
  output logic [15:0]       Data_dout,
  output logic              complete_data,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [15:0] mem [DEPTH];
  logic i_accept, i_fire, d_accept, d_fire;
  logic [ADDR_W-1:0] i_addr_q, d_addr_q;
  logic [15:0] d_din_q, i_dout_q, d_dout_q;
  logic d_rd_q;
  lc3_mem_port_fsm #(.LAT(I_LAT)) u_ifsm (
    .clock      (clock),
    .reset      (reset),
    .req_i      (I_macc && instrmem_rd),
    .accept_o   (i_accept),
    .fire_o     (i_fire),
    .complete_o (complete_instr)
  );
  lc3_mem_port_fsm #(.LAT(D_LAT)) u_dfsm (
    .clock      (clock),
    .reset      (reset),
    .req_i      (D_macc),
    .accept_o   (d_accept),
    .fire_o     (d_fire),
    .complete_o (complete_data)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      i_addr_q <= '0;
      d_addr_q <= '0;
      d_din_q  <= '0;
      d_rd_q   <= 1'b0;
      i_dout_q <= '0;
      d_dout_q <= '0;
    end else begin
      if (i_accept) i_addr_q <= ADDR_W'(pc);
      if (d_accept) begin
        d_addr_q <= ADDR_W'(Data_addr);
        d_din_q  <= Data_din;
        d_rd_q   <= Data_rd;
      end
      if (i_fire) i_dout_q <= mem[i_addr_q];
      if (d_fire && d_rd_q) d_dout_q <= mem[d_addr_q];
    end
  // Data write is last so it overrides a same-edge backdoor load; memory is never reset.
  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
    if (d_fire && !d_rd_q) mem[d_addr_q] <= d_din_q;
  end
  assign Instr_dout = i_dout_q;
  assign Data_dout  = d_dout_q;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: table-driven and hand-sequenced checks with a latency/data scoreboard per port.
module tb_lc3_mem_responder;
  localparam int I_LAT = 1;
  localparam int D_LAT = 2;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic I_macc = 1'b0, instrmem_rd = 1'b0, D_macc = 1'b0, Data_rd = 1'b0, load_en = 1'b0;
  logic [15:0] pc = '0, Data_addr = '0, Data_din = '0, load_data = '0;
  logic [7:0] load_addr = '0;
  logic [15:0] Instr_dout, Data_dout;
  logic complete_instr, complete_data;
  logic d0_macc = 1'b0, i0_macc = 1'b0;
  logic [15:0] i0_dout, d0_dout;
  logic i0_cmp, d0_cmp;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int i_pulses = 0, d_pulses = 0;
  logic [15:0] d_hold = '0;
  typedef struct {
    int          due;
    logic [15:0] exp;
  } sb_t;
  sb_t iq[$], dq[$];
  int d0_q[$];

  lc3_mem_responder #(.ADDR_W(8), .I_LAT(I_LAT), .D_LAT(D_LAT)) u_dut (
    .clock(clock), .reset(reset), .I_macc(I_macc), .instrmem_rd(instrmem_rd), .pc(pc),
    .D_macc(D_macc), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr), .Data_dout(Data_dout),
    .complete_data(complete_data), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );
  lc3_mem_responder #(.ADDR_W(8), .I_LAT(1), .D_LAT(0)) u_dut0 (
    .clock(clock), .reset(reset), .I_macc(i0_macc), .instrmem_rd(instrmem_rd), .pc(pc),
    .D_macc(d0_macc), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Instr_dout(i0_dout), .complete_instr(i0_cmp), .Data_dout(d0_dout),
    .complete_data(d0_cmp), .load_en(1'b0), .load_addr(8'h00), .load_data(16'h0000)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    sb_t s;
    if (d0_cmp) d0_q.push_back(cyc);
    if (complete_instr) begin
      i_pulses++;
      if (iq.size() == 0) check("instr_spurious_complete", 1, 0);
      else begin
        s = iq.pop_front();
        check("instr_latency", cyc, s.due);
        check("instr_dout", Instr_dout, s.exp);
      end
    end else if (iq.size() != 0 && cyc > iq[0].due) begin
      check("instr_missing_complete", 0, 1);
      void'(iq.pop_front());
    end
    if (complete_data) begin
      d_pulses++;
      if (dq.size() == 0) check("data_spurious_complete", 1, 0);
      else begin
        s = dq.pop_front();
        check("data_latency", cyc, s.due);
        check("data_dout", Data_dout, s.exp);
      end
    end else if (dq.size() != 0 && cyc > dq[0].due) begin
      check("data_missing_complete", 0, 1);
      void'(dq.pop_front());
    end
  end

  // Drive one request at the current negedge; it is sampled on the next rising edge.
  task automatic issue(input bit instr, input bit rd, input logic [15:0] a, input logic [15:0] w,
                       input logic [15:0] e);
    if (instr) begin
      I_macc = 1'b1; instrmem_rd = 1'b1; pc = a;
      iq.push_back('{cyc + 2 + I_LAT, e});
    end else begin
      D_macc = 1'b1; Data_rd = rd; Data_addr = a; Data_din = w;
      if (rd) d_hold = e;
      dq.push_back('{cyc + 2 + D_LAT, d_hold});
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (iq.size() != 0 || dq.size() != 0); k++) @(negedge clock);
    if (iq.size() != 0 || dq.size() != 0) begin
      check("drain_timeout", iq.size() + dq.size(), 0);
      iq.delete();
      dq.delete();
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  typedef struct {
    bit          instr;
    bit          rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[13];

  initial begin
    int i0, d0, c0;
    vecs[0]  = '{0, 0, 16'h0005, 16'hBEEF, 16'h0000};
    vecs[1]  = '{0, 1, 16'h0005, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1, 1, 16'h0010, 16'h0000, 16'h1234};
    vecs[3]  = '{1, 1, 16'h0110, 16'h0000, 16'h1234};
    vecs[4]  = '{0, 0, 16'h0107, 16'hA5A5, 16'h0000};
    vecs[5]  = '{1, 1, 16'h0007, 16'h0000, 16'hA5A5};
    vecs[6]  = '{0, 1, 16'hFF07, 16'h0000, 16'hA5A5};
    vecs[7]  = '{0, 0, 16'h00FF, 16'h0F0F, 16'h0000};
    vecs[8]  = '{0, 1, 16'h00FF, 16'h0000, 16'h0F0F};
    vecs[9]  = '{1, 1, 16'h0005, 16'h0000, 16'hBEEF};
    vecs[10] = '{0, 0, 16'h0005, 16'h1111, 16'h0000};
    vecs[11] = '{0, 1, 16'h0010, 16'h0000, 16'h1234};
    vecs[12] = '{1, 1, 16'h0405, 16'h0000, 16'h1111};
    repeat (2) @(negedge clock);
    check("rst_complete_instr", complete_instr, 0);
    check("rst_complete_data", complete_data, 0);
    check("rst_instr_dout", Instr_dout, 0);
    check("rst_data_dout", Data_dout, 0);
    @(negedge clock);
    reset = 1'b1;
    preload(8'h10, 16'h1234);
    preload(8'h20, 16'h0001);
    preload(8'h40, 16'h7777);
    for (int v = 0; v < 13; v++) begin
      @(negedge clock);
      issue(vecs[v].instr, vecs[v].rd, vecs[v].addr, vecs[v].wdata, vecs[v].exp);
      @(negedge clock);
      I_macc = 1'b0; D_macc = 1'b0;
      drain();
    end
    // Data write commits on the same edge the instruction read samples: read returns the old word.
    @(negedge clock);
    issue(0, 0, 16'h0020, 16'h0002, 16'h0000);
    @(negedge clock);
    D_macc = 1'b0;
    issue(1, 1, 16'h0020, 16'h0000, 16'h0001);
    @(negedge clock);
    I_macc = 1'b0;
    drain();
    @(negedge clock);
    issue(0, 1, 16'h0020, 16'h0000, 16'h0002);
    @(negedge clock);
    D_macc = 1'b0;
    drain();
    // Backdoor load and data write to the same word on the same edge: the data write wins.
    @(negedge clock);
    issue(0, 0, 16'h0030, 16'h5555, 16'h0000);
    @(negedge clock);
    D_macc = 1'b0;
    repeat (2) @(negedge clock);
    load_en = 1'b1; load_addr = 8'h30; load_data = 16'hAAAA;
    @(negedge clock);
    load_en = 1'b0;
    drain();
    @(negedge clock);
    issue(0, 1, 16'h0030, 16'h0000, 16'h5555);
    @(negedge clock);
    D_macc = 1'b0;
    drain();
    // I_macc without instrmem_rd must not start an access.
    i0 = i_pulses;
    @(negedge clock);
    I_macc = 1'b1; instrmem_rd = 1'b0; pc = 16'h0010;
    repeat (5) @(negedge clock);
    I_macc = 1'b0;
    repeat (3) @(negedge clock);
    check("imacc_without_rd_pulses", i_pulses - i0, 0);
    // Request held through WAIT and DONE yields a single access.
    i0 = i_pulses;
    @(negedge clock);
    issue(1, 1, 16'h0010, 16'h0000, 16'h1234);
    repeat (3) @(negedge clock);
    I_macc = 1'b0;
    drain();
    repeat (3) @(negedge clock);
    check("held_macc_single_pulse", i_pulses - i0, 1);
    // Reset in the middle of a write's WAIT phase.
    d0 = d_pulses;
    @(negedge clock);
    D_macc = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0040; Data_din = 16'h9999;
    @(negedge clock);
    D_macc = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_complete_instr", complete_instr, 0);
    check("midrst_complete_data", complete_data, 0);
    check("midrst_instr_dout", Instr_dout, 0);
    check("midrst_data_dout", Data_dout, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    d_hold = '0;
    repeat (6) @(negedge clock);
    check("midrst_no_data_pulse", d_pulses - d0, 0);
    @(negedge clock);
    issue(0, 1, 16'h0040, 16'h0000, 16'h7777);
    @(negedge clock);
    D_macc = 1'b0;
    drain();
    // Zero-latency data port with D_macc held for 10 edges: one completion every 3 cycles.
    @(negedge clock);
    d0_q.delete();
    c0 = cyc;
    Data_rd = 1'b1; Data_addr = 16'h0000; d0_macc = 1'b1;
    repeat (10) @(negedge clock);
    d0_macc = 1'b0;
    repeat (5) @(negedge clock);
    check("dlat0_pulse_count", d0_q.size(), 4);
    for (int k = 0; k < 4 && k < d0_q.size(); k++) check("dlat0_pulse_cycle", d0_q[k], c0 + 2 + 3 * k);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 Parameter ADDR_W, 8, word-address bits used; memory depth is 2**ADDR_W x 16.
REQ-002 Parameter I_LAT, 1, instruction-port wait cycles, legal range 0..15.
REQ-003 Parameter D_LAT, 2, data-port wait cycles, legal range 0..15.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 I_macc  in  1  instruction memory access request.
REQ-007 instrmem_rd  in  1  instruction read qualifier.
REQ-008 pc  in  16  instruction word address.
REQ-009 D_macc  in  1  data memory access request.
REQ-010 Data_rd  in  1  1 = read, 0 = write.
REQ-011 Data_addr  in  16  data word address.
REQ-012 Data_din  in  16  write data.
REQ-013 Instr_dout  out  16  instruction read data.
REQ-014 complete_instr  out  1  one-cycle instruction completion pulse.
REQ-015 Data_dout  out  16  data read data.
REQ-016 complete_data  out  1  one-cycle data completion pulse.
REQ-017 load_en / load_addr[ADDR_W] / load_data[16]  in  backdoor preload write.

Function
REQ-018 Each port SHALL run an independent FSM with states IDLE, WAIT and DONE.
REQ-019 Instruction port SHALL accept a request in IDLE when I_macc=1 and instrmem_rd=1; I_macc alone SHALL be ignored.
REQ-020 Data port SHALL accept a request in IDLE when D_macc=1, latching Data_rd, Data_addr and Data_din.
REQ-021 On accept, FSM SHALL enter WAIT with counter=LAT; in WAIT it SHALL go to DONE when counter=0, else decrement.
REQ-022 For a request accepted at edge N, complete_x SHALL be high only during cycle N+LAT+1 to N+LAT+2 (LAT+1 cycles latency), then the FSM SHALL return to IDLE.
REQ-023 Requests SHALL be sampled only in IDLE; macc held through WAIT/DONE SHALL NOT start a second access, and a new access SHALL need macc high in IDLE.
REQ-024 Addresses SHALL use the low ADDR_W bits only; upper bits alias (wrap-around).
REQ-025 Read data SHALL be sampled from memory on the edge entering DONE and held on *_dout until the next read completion.
REQ-026 A data write SHALL commit to memory on the edge entering DONE; Data_dout SHALL be unchanged by writes.
REQ-027 Instruction read and data write to the same address on the same edge SHALL return the old value.
REQ-028 load_en SHALL write load_data to load_addr on any edge; a same-edge, same-address data write SHALL win.
REQ-029 Both ports SHALL complete concurrently without mutual stall.

Reset
REQ-030 Asserting reset SHALL force both FSMs to IDLE and clear counters, complete_instr, complete_data, Instr_dout and Data_dout to 0.
REQ-031 Reset mid-operation SHALL drop pending accesses without committing a write; memory contents SHALL be preserved.
REQ-032 The first accept after reset deassertion SHALL occur no earlier than the first rising edge with reset high.

Structure
REQ-033 Package lc3_mem_pkg SHALL hold the port state enum, the ADDR_W default and the LAT_MAX=15 constant.
REQ-034 Sub-module lc3_mem_port_fsm (accept/WAIT/DONE sequencer with latency counter) SHALL be instantiated once per port.

Verification
REQ-035 Preload 0x10 with 0x1234, pulse I_macc+instrmem_rd with pc=0x0010 at edge N (I_LAT=1) -> complete_instr high in cycle N+2 only, Instr_dout=0x1234.
REQ-036 Data write 0xBEEF to 0x0005 with D_LAT=2, then read it back -> each complete_data arrives 3 cycles after accept; readback Data_dout=0xBEEF.
REQ-037 Same-edge instruction read and data write to address 0x20, old value 0x0001, new value 0x0002 -> Instr_dout=0x0001; later read returns 0x0002.
REQ-038 Read pc=0x0110 with ADDR_W=8 -> returns contents of word 0x10.
REQ-039 Assert reset during WAIT of a write -> no complete pulse, all outputs 0, target word unchanged.
REQ-040 Hold D_macc high for 10 cycles with D_LAT=0 -> complete_data pulses every 3 cycles (accept, DONE, IDLE re-accept).
